// File: rtl/rob_multi.sv
// rob_multi: parametrised reorder buffer with multi-port CDB completion,
// multi-lane in-order retire, occupancy tracking and mispredict squash.
//
// Ports (summary):
//   clock, reset_n             clock, async active-low reset
//   disp_*                     allocation handshake from ID; disp_tag = tail index
//   cdb_*                      CDB_W completion ports (valid/tag/value/mispred/target)
//   rd_tag/rd_value/rd_ready   two operand lookups
//   ret_*                      RETIRE_W retire lanes towards the register file
//   head_tag, count            head index and occupancy
//   squash, squash_pc          redirect while a mispredicted entry retires
//   halted                     sticky, set once a halt retires
//
// Optional feature: define ROB_CDB_FWD_EN to bypass same-cycle CDB results into the
// operand lookups. Without it, lookups see registered state only.
module rob_multi #(
  parameter int unsigned ROB_DEPTH = 32,
  parameter int unsigned RETIRE_W  = 2,
  parameter int unsigned CDB_W     = 2,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_IDX_W = 5,
  parameter int unsigned TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [REG_IDX_W-1:0]      disp_dest_idx,
  input  logic [XLEN-1:0]           disp_npc,
  input  logic                      disp_halt,
  input  logic                      disp_illegal,
  output logic [TAG_W-1:0]          disp_tag,
  input  logic [CDB_W-1:0]          cdb_valid,
  input  logic [CDB_W*TAG_W-1:0]    cdb_tag,
  input  logic [CDB_W*XLEN-1:0]     cdb_value,
  input  logic [CDB_W-1:0]          cdb_mispred,
  input  logic [CDB_W*XLEN-1:0]     cdb_target,
  input  logic [2*TAG_W-1:0]        rd_tag,
  output logic [2*XLEN-1:0]         rd_value,
  output logic [1:0]                rd_ready,
  output logic [RETIRE_W-1:0]       ret_valid,
  output logic [RETIRE_W*REG_IDX_W-1:0] ret_dest_idx,
  output logic [RETIRE_W*XLEN-1:0]  ret_value,
  output logic [RETIRE_W-1:0]       ret_wr_en,
  output logic [RETIRE_W*XLEN-1:0]  ret_npc,
  output logic [RETIRE_W-1:0]       ret_illegal,
  output logic [TAG_W-1:0]          head_tag,
  output logic                      squash,
  output logic [XLEN-1:0]           squash_pc,
  output logic                      halted,
  output logic [TAG_W:0]            count
);

  logic [ROB_DEPTH-1:0] alloc_q, alloc_d, done_q, done_d, mispred_q, mispred_d;
  logic [ROB_DEPTH-1:0] halt_q, halt_d, illegal_q, illegal_d;
  logic [REG_IDX_W-1:0] dest_q   [ROB_DEPTH];
  logic [REG_IDX_W-1:0] dest_d   [ROB_DEPTH];
  logic [XLEN-1:0]      value_q  [ROB_DEPTH];
  logic [XLEN-1:0]      value_d  [ROB_DEPTH];
  logic [XLEN-1:0]      npc_q    [ROB_DEPTH];
  logic [XLEN-1:0]      npc_d    [ROB_DEPTH];
  logic [XLEN-1:0]      target_q [ROB_DEPTH];
  logic [XLEN-1:0]      target_d [ROB_DEPTH];
  logic [TAG_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]       count_q, count_d;
  logic                 halted_q, halted_d;

  logic [TAG_W:0]       n_ret;
  logic [ROB_DEPTH-1:0] ret_clr;
  logic                 halt_ret;
  logic                 disp_fire;

  assign head_tag   = head_q;
  assign disp_tag   = tail_q;
  assign count      = count_q;
  assign halted     = halted_q;
  assign disp_ready = (count_q != (TAG_W+1)'(ROB_DEPTH)) && !squash && !halted_q;
  assign disp_fire  = disp_valid && disp_ready;

  // Retire: walk lanes from head; a lane stops the group once it is not ready
  // or once it is a mispredict/halt (that entry itself still retires).
  always_comb begin
    logic             go;
    logic [TAG_W-1:0] idx;
    ret_valid    = '0;
    ret_dest_idx = '0;
    ret_value    = '0;
    ret_wr_en    = '0;
    ret_npc      = '0;
    ret_illegal  = '0;
    squash       = 1'b0;
    squash_pc    = '0;
    halt_ret     = 1'b0;
    n_ret        = '0;
    ret_clr      = '0;
    idx          = '0;
    go           = !halted_q;
    for (int k = 0; k < RETIRE_W; k++) begin
      idx = head_q + TAG_W'(k);
      if (go && alloc_q[idx] && done_q[idx]) begin
        ret_valid[k]                           = 1'b1;
        ret_dest_idx[k*REG_IDX_W +: REG_IDX_W] = dest_q[idx];
        ret_value[k*XLEN +: XLEN]              = value_q[idx];
        ret_wr_en[k]                           = (dest_q[idx] != '0);
        ret_npc[k*XLEN +: XLEN]                = npc_q[idx];
        ret_illegal[k]                         = illegal_q[idx];
        ret_clr[idx]                           = 1'b1;
        n_ret                                  = n_ret + (TAG_W+1)'(1);
        if (mispred_q[idx]) begin
          squash    = 1'b1;
          squash_pc = target_q[idx];
        end
        if (halt_q[idx]) halt_ret = 1'b1;
        go = !(mispred_q[idx] || halt_q[idx]);
      end else begin
        go = 1'b0;
      end
    end
  end

  // Operand lookup.
  always_comb begin
    logic [TAG_W-1:0] t;
    rd_value = '0;
    rd_ready = '0;
    t        = '0;
    for (int i = 0; i < 2; i++) begin
      t = rd_tag[i*TAG_W +: TAG_W];
      rd_value[i*XLEN +: XLEN] = value_q[t];
      rd_ready[i]              = alloc_q[t] && done_q[t];
`ifdef ROB_CDB_FWD_EN
      // Descending loop so the lowest matching port has the final say.
      for (int p = CDB_W - 1; p >= 0; p--) begin
        if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == t) && alloc_q[t]) begin
          rd_value[i*XLEN +: XLEN] = cdb_value[p*XLEN +: XLEN];
          rd_ready[i]              = 1'b1;
        end
      end
`endif
    end
  end

  // Next state.
  always_comb begin
    logic [TAG_W-1:0] ct;
    alloc_d   = alloc_q;
    done_d    = done_q;
    mispred_d = mispred_q;
    halt_d    = halt_q;
    illegal_d = illegal_q;
    dest_d    = dest_q;
    value_d   = value_q;
    npc_d     = npc_q;
    target_d  = target_q;
    halted_d  = halted_q | halt_ret;
    head_d    = head_q + n_ret[TAG_W-1:0];
    tail_d    = tail_q;
    count_d   = count_q + (TAG_W+1)'(disp_fire) - n_ret;
    ct        = '0;
    // Descending loop so the lowest port wins on a shared tag.
    for (int p = CDB_W - 1; p >= 0; p--) begin
      ct = cdb_tag[p*TAG_W +: TAG_W];
      if (cdb_valid[p] && alloc_q[ct]) begin
        done_d[ct]    = 1'b1;
        value_d[ct]   = cdb_value[p*XLEN +: XLEN];
        mispred_d[ct] = cdb_mispred[p];
        target_d[ct]  = cdb_target[p*XLEN +: XLEN];
      end
    end
    alloc_d = alloc_d & ~ret_clr;
    done_d  = done_d & ~ret_clr;
    if (squash) begin
      alloc_d = '0;
      done_d  = '0;
      tail_d  = head_d;
      count_d = '0;
    end else if (disp_fire) begin
      alloc_d[tail_q]   = 1'b1;
      done_d[tail_q]    = 1'b0;
      mispred_d[tail_q] = 1'b0;
      halt_d[tail_q]    = disp_halt;
      illegal_d[tail_q] = disp_illegal;
      dest_d[tail_q]    = disp_dest_idx;
      npc_d[tail_q]     = disp_npc;
      tail_d            = tail_q + TAG_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alloc_q   <= '0;
      done_q    <= '0;
      mispred_q <= '0;
      halt_q    <= '0;
      illegal_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        dest_q[i]   <= '0;
        value_q[i]  <= '0;
        npc_q[i]    <= '0;
        target_q[i] <= '0;
      end
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      alloc_q   <= alloc_d;
      done_q    <= done_d;
      mispred_q <= mispred_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
      dest_q    <= dest_d;
      value_q   <= value_d;
      npc_q     <= npc_d;
      target_q  <= target_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      halted_q  <= halted_d;
    end
  end

endmodule

// File: tb/tb_rob_multi.sv
// Directed self-checking bench for rob_multi with default parameters.
module tb_rob_multi;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        disp_valid = 1'b0;
  logic        disp_ready;
  logic [4:0]  disp_dest_idx = '0;
  logic [31:0] disp_npc = '0;
  logic        disp_halt = 1'b0;
  logic        disp_illegal = 1'b0;
  logic [4:0]  disp_tag;
  logic [1:0]  cdb_valid = '0;
  logic [9:0]  cdb_tag = '0;
  logic [63:0] cdb_value = '0;
  logic [1:0]  cdb_mispred = '0;
  logic [63:0] cdb_target = '0;
  logic [9:0]  rd_tag = '0;
  logic [63:0] rd_value;
  logic [1:0]  rd_ready;
  logic [1:0]  ret_valid;
  logic [9:0]  ret_dest_idx;
  logic [63:0] ret_value;
  logic [1:0]  ret_wr_en;
  logic [63:0] ret_npc;
  logic [1:0]  ret_illegal;
  logic [4:0]  head_tag;
  logic        squash;
  logic [31:0] squash_pc;
  logic        halted;
  logic [5:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  rob_multi dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .disp_valid    (disp_valid),
    .disp_ready    (disp_ready),
    .disp_dest_idx (disp_dest_idx),
    .disp_npc      (disp_npc),
    .disp_halt     (disp_halt),
    .disp_illegal  (disp_illegal),
    .disp_tag      (disp_tag),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_value     (cdb_value),
    .cdb_mispred   (cdb_mispred),
    .cdb_target    (cdb_target),
    .rd_tag        (rd_tag),
    .rd_value      (rd_value),
    .rd_ready      (rd_ready),
    .ret_valid     (ret_valid),
    .ret_dest_idx  (ret_dest_idx),
    .ret_value     (ret_value),
    .ret_wr_en     (ret_wr_en),
    .ret_npc       (ret_npc),
    .ret_illegal   (ret_illegal),
    .head_tag      (head_tag),
    .squash        (squash),
    .squash_pc     (squash_pc),
    .halted        (halted),
    .count         (count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    disp_valid = 1'b0;
    cdb_valid  = '0;
    cdb_mispred = '0;
    reset_n    = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Allocate one entry; the handshake happens on the next edge.
  task automatic disp(input logic [4:0] d, input logic [31:0] npc, input logic h);
    disp_valid    = 1'b1;
    disp_dest_idx = d;
    disp_npc      = npc;
    disp_halt     = h;
    tick();
    disp_valid = 1'b0;
    disp_halt  = 1'b0;
  endtask

  task automatic cdb_set(input int p, input logic [4:0] t, input logic [31:0] v,
                         input logic m, input logic [31:0] tgt);
    cdb_valid[p]           = 1'b1;
    cdb_tag[p*5 +: 5]      = t;
    cdb_value[p*32 +: 32]  = v;
    cdb_mispred[p]         = m;
    cdb_target[p*32 +: 32] = tgt;
  endtask

  initial begin
    do_reset();
    check("rst_count", count, 0);
    check("rst_ready", disp_ready, 1);
    check("rst_ret_valid", ret_valid, 0);
    check("rst_squash", squash, 0);
    check("rst_squash_pc", squash_pc, 0);
    check("rst_rd_ready", rd_ready, 0);
    check("rst_rd_value", rd_value, 0);
    check("rst_head", head_tag, 0);
    check("rst_halted", halted, 0);

    // Four dispatches, two-port completion out of order, dual retire.
    for (int i = 0; i < 4; i++) begin
      disp_valid    = 1'b1;
      disp_dest_idx = 5'(i + 1);
      disp_npc      = 32'h100 + 32'(4 * i);
      #1;
      check("disp_tag", disp_tag, 64'(i));
      tick();
    end
    disp_valid = 1'b0;
    #1;
    check("count4", count, 4);
    cdb_set(0, 5'd1, 32'h11, 1'b0, 32'h0);
    cdb_set(1, 5'd0, 32'h10, 1'b0, 32'h0);
    rd_tag = {5'd1, 5'd0};
    #1;
`ifdef ROB_CDB_FWD_EN
    check("rd_ready_cdb_cycle", rd_ready, 2'b11);
`else
    check("rd_ready_cdb_cycle", rd_ready, 2'b00);
`endif
    tick();
    cdb_valid = '0;
    #1;
    check("rd_ready_after", rd_ready, 2'b11);
    check("rd_value_after", rd_value, {32'h11, 32'h10});
    check("ret_valid2", ret_valid, 2'b11);
    check("ret_value2", ret_value, {32'h11, 32'h10});
    check("ret_dest2", ret_dest_idx, {5'd2, 5'd1});
    check("ret_wr_en2", ret_wr_en, 2'b11);
    check("ret_npc2", ret_npc, {32'h104, 32'h100});
    tick();
    check("head2", head_tag, 2);
    check("count2", count, 2);

    // Same tag on both ports: port 0 wins. Tag 3 still pending, single lane.
    cdb_set(0, 5'd2, 32'hAA, 1'b0, 32'h0);
    cdb_set(1, 5'd2, 32'hBB, 1'b0, 32'h0);
    tick();
    cdb_valid = '0;
    #1;
    check("prio_ret_valid", ret_valid, 2'b01);
    check("prio_value", ret_value[31:0], 32'hAA);

    // Fill to full, retire one, then tail wraps to 0.
    do_reset();
    disp_valid    = 1'b1;
    disp_dest_idx = 5'd7;
    for (int i = 0; i < 32; i++) tick();
    check("full_count", count, 32);
    check("full_ready", disp_ready, 0);
    cdb_set(0, 5'd0, 32'h55, 1'b0, 32'h0);
    tick();
    cdb_valid = '0;
    #1;
    check("full_ret_valid", ret_valid, 2'b01);
    check("full_ready_in_retire", disp_ready, 0);
    tick();
    check("after_ret_count", count, 31);
    check("after_ret_ready", disp_ready, 1);
    check("wrap_tag", disp_tag, 0);
    tick();
    disp_valid = 1'b0;
    #1;
    check("refull_count", count, 32);

    // Mispredict squash.
    do_reset();
    disp(5'd1, 32'h40, 1'b0);
    disp(5'd2, 32'h44, 1'b0);
    disp(5'd3, 32'h48, 1'b0);
    cdb_set(0, 5'd1, 32'h1, 1'b0, 32'h0);
    cdb_set(1, 5'd2, 32'h2, 1'b0, 32'h0);
    tick();
    cdb_valid = '0;
    cdb_set(0, 5'd0, 32'h0, 1'b1, 32'h200);
    tick();
    cdb_valid   = '0;
    cdb_mispred = '0;
    disp_valid  = 1'b1;
    #1;
    check("sq_ret_valid", ret_valid, 2'b01);
    check("sq_squash", squash, 1);
    check("sq_pc", squash_pc, 32'h200);
    check("sq_ready", disp_ready, 0);
    check("sq_wr_en", ret_wr_en, 2'b01);
    tick();
    disp_valid = 1'b0;
    #1;
    check("sq_count", count, 0);
    check("sq_head", head_tag, 1);
    check("sq_tail", disp_tag, 1);
    check("sq_clear", squash, 0);
    check("sq_idle", ret_valid, 0);

    // Halt.
    do_reset();
    disp(5'd3, 32'h80, 1'b1);
    disp(5'd4, 32'h84, 1'b0);
    cdb_set(0, 5'd0, 32'h0, 1'b0, 32'h0);
    cdb_set(1, 5'd1, 32'h9, 1'b0, 32'h0);
    tick();
    cdb_valid = '0;
    #1;
    check("halt_ret_valid", ret_valid, 2'b01);
    check("halt_before", halted, 0);
    tick();
    check("halted", halted, 1);
    check("halt_ready", disp_ready, 0);
    check("halt_idle", ret_valid, 0);
    check("halt_count", count, 1);

    // Destination 0: retires without a register write.
    do_reset();
    disp(5'd0, 32'hC0, 1'b0);
    cdb_set(0, 5'd0, 32'h77, 1'b0, 32'h0);
    tick();
    cdb_valid = '0;
    #1;
    check("d0_ret_valid", ret_valid, 2'b01);
    check("d0_wr_en", ret_wr_en, 2'b00);

    // Asynchronous reset between edges.
    do_reset();
    for (int i = 0; i < 5; i++) disp(5'(i + 1), 32'h0, 1'b0);
    check("pre_async_count", count, 5);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("async_count", count, 0);
    check("async_ready", disp_ready, 1);
    check("async_head", head_tag, 0);
    reset_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rob_multi.md
# rob_multi

Parametrised reorder buffer. Replaces the single-issue ROB with configurable depth, multi-port CDB completion, multi-lane in-order retire, occupancy-based full/empty tracking and a redirect PC on branch-mispredict squash. It sits between the ID/dispatch stage, the reservation stations and map table (tags, operand lookup), the CDB, and the architectural register file (retire).

## Interface
Parameters:
- ROB_DEPTH, 32: number of entries. Must be a power of 2 and at least 4.
- RETIRE_W, 2: maximum retires per cycle, 1..4.
- CDB_W, 2: number of CDB completion ports.
- XLEN, 32: data and PC width.
- REG_IDX_W, 5: architectural register index width.
- TAG_W = $clog2(ROB_DEPTH): derived.

Ports:
- clock  in  1  single clock. All state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- disp_valid  in  1  ID has an instruction to allocate.
- disp_ready  out  1  an entry can be allocated this cycle.
- disp_dest_idx  in  REG_IDX_W  destination register. 0 means no writeback.
- disp_npc  in  XLEN  NPC of the instruction.
- disp_halt  in  1  instruction is a halt.
- disp_illegal  in  1  instruction is illegal.
- disp_tag  out  TAG_W  tag assigned on the handshake. Equals the tail index.
- cdb_valid  in  CDB_W  completion valid, one bit per port.
- cdb_tag  in  CDB_W*TAG_W  completing entry, per port.
- cdb_value  in  CDB_W*XLEN  result, per port.
- cdb_mispred  in  CDB_W  branch resolved opposite to its prediction.
- cdb_target  in  CDB_W*XLEN  correct next PC for a mispredicted branch.
- rd_tag  in  2*TAG_W  operand lookup tags for rs1 and rs2.
- rd_value  out  2*XLEN  stored value for each lookup.
- rd_ready  out  2  each looked-up entry is allocated and complete.
- ret_valid  out  RETIRE_W  lane retires this cycle.
- ret_dest_idx  out  RETIRE_W*REG_IDX_W  per-lane destination register.
- ret_value  out  RETIRE_W*XLEN  per-lane result.
- ret_wr_en  out  RETIRE_W  ret_valid and dest not equal to 0.
- ret_npc  out  RETIRE_W*XLEN  per-lane NPC.
- ret_illegal  out  RETIRE_W  per-lane illegal flag.
- head_tag  out  TAG_W  current head index.
- squash  out  1  mispredict recovery this cycle.
- squash_pc  out  XLEN  redirect target while squash is high.
- halted  out  1  sticky. A halt has retired.
- count  out  TAG_W+1  number of occupied entries.

## Operation
- Each entry holds: alloc, done, mispred, halt, illegal, dest_idx, value, npc, target.
- **Dispatch:** an allocation happens when disp_valid and disp_ready are both high.
  - The tail entry is written with alloc=1, done=0, mispred=0 and the dispatch fields.
  - tail advances by 1, wrapping modulo ROB_DEPTH.
  - disp_ready = (count != ROB_DEPTH) && !squash && !halted.
- **Complete:** for each port p with cdb_valid[p] high and the addressed entry allocated, the entry gets done=1, value, mispred and target.
  - A CDB write to an unallocated entry is ignored.
  - If two ports carry the same tag, the lower port index wins.
- **Retire:** lane k is valid when entry head+k is alloc and done, and every lane j<k is valid and not a stop.
  - A stop is an entry with mispred or halt set. The retire group ends with that entry.
  - On retire, entries clear to alloc=0, head advances by the number of valid lanes, and count is updated.
- **Squash:** asserted combinationally in the cycle a mispredicted entry retires. squash_pc is that entry's target.
  - The mispredicted entry still retires normally, including its register write.
  - On that edge, all other entries clear to alloc=0. tail is set to the new head and count to 0.
  - A dispatch offered in that cycle is not accepted.
- **Halt:** when a halt entry retires, halted sets on that edge.
  - Afterwards, retire stays idle and dispatch is blocked until reset.
- **Lookup:** rd_value and rd_ready are combinational reads from state.
- **Count arithmetic:** count_next = count + accepted_dispatch − retired_lanes, width TAG_W+1.
  - Full is count == ROB_DEPTH. Empty is count == 0.
  - When head == tail, full and empty are told apart by count alone.

## Timing
- Reset (reset_n low) gives:
  - head = 0, tail = 0, count = 0, all alloc/done = 0, halted = 0.
  - disp_ready = 1, every ret_* output = 0, squash = 0, squash_pc = 0, rd_ready = 0, rd_value = 0.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- An entry allocated at edge N can take a CDB completion in cycle N.
- That completed entry can retire in cycle N+1, at the earliest.
- A retire frees its entry at the end of that cycle. A full ROB does not accept a dispatch in the same cycle as a retire, because disp_ready is computed from the current count.
- disp_tag is valid combinationally in the cycle of the handshake.

## Configuration
- ROB_CDB_FWD_EN defined:
  - Lookup results bypass the same-cycle CDB. If a cdb_valid port matches rd_tag of an allocated entry, rd_value is that port's value and rd_ready is 1.
  - Retire does not bypass the CDB.
- ROB_CDB_FWD_EN undefined: lookup reflects registered state only, so completion becomes visible one cycle later.

## Test plan
- Reset, then dispatch 4 instructions with dest 1..4. Expected: disp_tag 0,1,2,3 and count=4.
  - Complete tags 1 and 0 on the two CDB ports with values 0x11 and 0x10 in one cycle.
  - Next cycle: ret_valid=2'b11, values 0x10 and 0x11, head_tag=2.
- Fill to ROB_DEPTH entries. Expected: disp_ready=0, count=32.
  - Retire one entry. Expected: disp_ready=1 the following cycle and tail wraps to index 0.
- Dispatch a branch at tag 0, then tags 1 and 2. Complete all three, with tag 0 carrying mispred=1 and target 0x200.
  - Expected: a single-lane retire, squash=1, squash_pc=0x200, then count=0 and head=tail=1.
- Dispatch a halt at tag 0 and an ALU op at tag 1, then complete both.
  - Expected: only lane 0 retires, halted=1 afterwards, and disp_ready stays 0.
- Dispatch an instruction with dest 0. On retire, expect ret_valid=1 and ret_wr_en=0.
- Drop reset_n low between clock edges while count=5. Expected: count=0 and disp_ready=1 with no clock edge.
